token_divider_multi: RTL and testbench
======================================

// Module: token_divider_multi
// PURPOSE
//  Multi-channel serial token thinner: each of CHANNELS independent 1-bit streams passes
//  one of every DIV incoming '1' tokens; all other '1's are dropped.
//  Runtime-loadable divisor, keep-first/keep-last selection and a global passed-token counter.
//  Sits in the sequential-basics stream-processing chain, downstream of token sources.
// PARAMETERS
//  CHANNELS   4   number of independent token streams
//  DIV_W      4   divisor width; usable divisor 1..2**DIV_W-1
//  CNT_W      16  width of the saturating passed-token counter
// PORTS
//  clk          in   1            rising-edge clock, sole clock domain
//  rst_n        in   1            synchronous, active-low reset
//  en           in   1            global enable; 0 = freeze phases, block all output
//  load         in   1            1-cycle strobe: capture div_in/mode_in, restart all phases
//  div_in       in   DIV_W        new divisor, sampled only when load=1
//  mode_in      in   1            new mode, sampled only when load=1 (0=KEEP_LAST, 1=KEEP_FIRST)
//  clr_cnt      in   1            synchronous clear of passed_cnt/cnt_sat
//  a            in   CHANNELS     incoming token per channel
//  b            out  CHANNELS     thinned token per channel
//  passed_cnt   out  CNT_W        total tokens emitted on b, all channels
//  cnt_sat      out  1            sticky: passed_cnt reached all-ones
// BEHAVIOUR
//  - Reset (rst_n=0 at posedge): phases=0, div_r=2, mode_r=KEEP_LAST, passed_cnt=0, cnt_sat=0.
//    b is forced 0 in any cycle where rst_n=0.
//  - Per channel phase ph (DIV_W bits) counts accepted '1' tokens modulo div_eff.
//    div_eff = (div_r==0) ? 1 : div_r.
//  - Zero latency: b[i] is combinational, a[i] & en & rst_n & hit[i].
//    KEEP_LAST:  hit = (ph == div_eff-1).
//    KEEP_FIRST: hit = (ph == 0).
//  - Phase update at posedge when en & a[i]: ph <= (ph==div_eff-1) ? 0 : ph+1.
//    a[i]=0 or en=0: ph holds.
//  - div_eff=1: every token passes in both modes (pure pass-through).
//  - load=1: the current cycle's b uses the old div_r/mode_r/ph.
//    Next cycle: div_r<=div_in, mode_r<=mode_in, all ph<=0; load overrides that cycle's phase advance.
//  - passed_cnt += popcount(b) each cycle. Saturates at 2**CNT_W-1 (no wrap); cnt_sat set on reaching max.
//  - clr_cnt=1: passed_cnt<=0, cnt_sat<=0; this cycle's tokens are not counted. Phases unaffected.
//  - Priority at posedge: rst_n low > load > normal advance. clr_cnt is independent of load.
//  - Reset mid-stream: all state returns to reset values in one cycle.
//    First token after release is judged against ph=0, div=2, KEEP_LAST (dropped).
//  - Channels fully independent; simultaneous tokens on all channels are all counted.
// STRUCTURE
//  - Package token_div_pkg: typedef enum logic {KEEP_LAST=1'b0, KEEP_FIRST=1'b1} keep_mode_e;
//    localparam DEFAULT_DIV=2.
//  - Sub-module token_div_channel (per-channel phase counter + hit decode),
//    instantiated CHANNELS times via generate.
//  - Top owns div_r/mode_r, the popcount adder and the saturating counter.
// TESTING
//  1. div=2 KEEP_LAST, ch0 a=110_011_101_000_1111 -> b=010_001_001_000_0101, passed_cnt=5.
//  2. load div=3 KEEP_FIRST, ch1 a=1111_1111 -> b=1001_0010; other channels idle stay 0.
//  3. load div=0, then div=1: any a pattern -> b==a, passed_cnt increments by popcount(a).
//  4. load asserted with a=1 while ph=div-1 (div=2):
//     token passes with old settings; next token judged from ph=0.
//  5. CNT_W=4, all 4 channels a=1, div=1: passed_cnt 0->4->8->12->15 (saturates), cnt_sat=1;
//     clr_cnt -> 0, cnt_sat=0.
//  6. rst_n low mid-stream (ph=1, div=3): b=0 during reset; after release, div=2 KEEP_LAST,
//     first '1' dropped, second passed. en=0 cycles: b=0, phase frozen.

Source files
------------

// File: rtl/token_div_pkg.sv
// Shared types and constants for the token divider.
// Provides the keep-mode enum and the reset divisor.
package token_div_pkg;

    typedef enum logic {
        KEEP_LAST  = 1'b0,
        KEEP_FIRST = 1'b1
    } keep_mode_e;

    localparam int DEFAULT_DIV = 2;

endpackage

// File: rtl/token_div_channel.sv
// One channel: phase counter over accepted tokens plus hit decode.
// Ports: clk, rst_n, en, load, a (token in), div_eff, mode, b (token out).
module token_div_channel
    import token_div_pkg::*;
#(
    parameter int DIV_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             load,
    input  logic             a,
    input  logic [DIV_W-1:0] div_eff,
    input  keep_mode_e       mode,
    output logic             b
);

    logic [DIV_W-1:0] ph;
    logic             last;
    logic             hit;

    // div_eff is never zero, so div_eff-1 cannot underflow.
    assign last = (ph == div_eff - 1'b1);
    assign hit  = (mode == KEEP_FIRST) ? (ph == '0) : last;
    assign b    = a & en & rst_n & hit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ph <= '0;
        end else if (load) begin
            ph <= '0;
        end else if (en && a) begin
            ph <= last ? '0 : ph + 1'b1;
        end
    end

endmodule

// File: rtl/token_divider_multi.sv
// Multi-channel token thinner: passes one of every div '1' tokens per channel.
// Ports: clk, rst_n, en, load, div_in, mode_in, clr_cnt, a -> b, passed_cnt, cnt_sat.
module token_divider_multi
    import token_div_pkg::*;
#(
    parameter int CHANNELS = 4,
    parameter int DIV_W    = 4,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                load,
    input  logic [DIV_W-1:0]    div_in,
    input  logic                mode_in,
    input  logic                clr_cnt,
    input  logic [CHANNELS-1:0] a,
    output logic [CHANNELS-1:0] b,
    output logic [CNT_W-1:0]    passed_cnt,
    output logic                cnt_sat
);

    logic [DIV_W-1:0] div_r;
    logic [DIV_W-1:0] div_eff;
    keep_mode_e       mode_r;
    logic [CNT_W:0]   sum;
    logic             full;

    // A zero divisor behaves as pass-through.
    assign div_eff = (div_r == '0) ? DIV_W'(1) : div_r;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_r  <= DIV_W'(DEFAULT_DIV);
            mode_r <= KEEP_LAST;
        end else if (load) begin
            div_r  <= div_in;
            mode_r <= keep_mode_e'(mode_in);
        end
    end

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        token_div_channel #(
            .DIV_W(DIV_W)
        ) u_ch (
            .clk    (clk),
            .rst_n  (rst_n),
            .en     (en),
            .load   (load),
            .a      (a[i]),
            .div_eff(div_eff),
            .mode   (mode_r),
            .b      (b[i])
        );
    end

    // One extra bit catches overshoot past all-ones before clamping.
    always_comb begin
        sum = {1'b0, passed_cnt};
        for (int i = 0; i < CHANNELS; i++) begin
            sum = sum + {{CNT_W{1'b0}}, b[i]};
        end
    end

    assign full = (sum >= {1'b0, {CNT_W{1'b1}}});

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            passed_cnt <= '0;
            cnt_sat    <= 1'b0;
        end else if (clr_cnt) begin
            passed_cnt <= '0;
            cnt_sat    <= 1'b0;
        end else if (full) begin
            passed_cnt <= '1;
            cnt_sat    <= 1'b1;
        end else begin
            passed_cnt <= sum[CNT_W-1:0];
        end
    end

endmodule

// File: tb/tb_token_divider_multi.sv
// Directed self-checking bench for token_divider_multi.
// A second instance with a 4-bit counter exercises saturation.
module tb_token_divider_multi;

    logic        clk;
    logic        rst_n;
    logic        en;
    logic        load;
    logic [3:0]  div_in;
    logic        mode_in;
    logic        clr_cnt;
    logic [3:0]  a;
    logic [3:0]  b;
    logic [15:0] passed_cnt;
    logic        cnt_sat;
    logic [3:0]  b4;
    logic [3:0]  passed_cnt4;
    logic        cnt_sat4;

    int checks = 0;
    int passes = 0;

    token_divider_multi #(
        .CHANNELS(4), .DIV_W(4), .CNT_W(16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .load      (load),
        .div_in    (div_in),
        .mode_in   (mode_in),
        .clr_cnt   (clr_cnt),
        .a         (a),
        .b         (b),
        .passed_cnt(passed_cnt),
        .cnt_sat   (cnt_sat)
    );

    token_divider_multi #(
        .CHANNELS(4), .DIV_W(4), .CNT_W(4)
    ) dut4 (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .load      (load),
        .div_in    (div_in),
        .mode_in   (mode_in),
        .clr_cnt   (clr_cnt),
        .a         (a),
        .b         (b4),
        .passed_cnt(passed_cnt4),
        .cnt_sat   (cnt_sat4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Inputs change 1 time unit after posedge; b is checked mid-cycle.
    task automatic cyc(input string tag, input logic [3:0] av,
                       input logic [3:0] bexp);
        a = av;
        #4;
        chk(tag, {28'd0, b}, {28'd0, bexp});
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [3:0] d, input logic m);
        load    = 1'b1;
        div_in  = d;
        mode_in = m;
        a       = 4'd0;
        @(posedge clk);
        #1;
        load = 1'b0;
    endtask

    logic [15:0] va;
    logic [15:0] vb;
    logic [7:0]  va8;
    logic [7:0]  vb8;

    initial begin
        rst_n   = 1'b0;
        en      = 1'b1;
        load    = 1'b0;
        div_in  = 4'd0;
        mode_in = 1'b0;
        clr_cnt = 1'b0;
        a       = 4'hF;
        @(posedge clk);
        @(posedge clk);
        #1;
        #4;
        chk("rst_b", {28'd0, b}, 32'd0);
        chk("rst_cnt", {16'd0, passed_cnt}, 32'd0);
        chk("rst_sat", {31'd0, cnt_sat}, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        a     = 4'd0;

        // div=2 keep-last on channel 0
        va = 16'b1100111010001111;
        vb = 16'b0100010010000101;
        for (int i = 15; i >= 0; i--) begin
            cyc("t1_b", {3'd0, va[i]}, {3'd0, vb[i]});
        end
        chk("t1_cnt", {16'd0, passed_cnt}, 32'd5);

        // div=3 keep-first on channel 1
        do_load(4'd3, 1'b1);
        va8 = 8'b11111111;
        vb8 = 8'b10010010;
        for (int i = 7; i >= 0; i--) begin
            cyc("t2_b", {2'd0, va8[i], 1'b0}, {2'd0, vb8[i], 1'b0});
        end
        chk("t2_cnt", {16'd0, passed_cnt}, 32'd8);

        // div=0 and div=1 are pass-through
        do_load(4'd0, 1'b0);
        cyc("t3_d0", 4'b1011, 4'b1011);
        cyc("t3_d0", 4'b1111, 4'b1111);
        cyc("t3_d0", 4'b0110, 4'b0110);
        chk("t3_cnt0", {16'd0, passed_cnt}, 32'd17);
        do_load(4'd1, 1'b1);
        cyc("t3_d1", 4'b1101, 4'b1101);
        cyc("t3_d1", 4'b0001, 4'b0001);
        chk("t3_cnt1", {16'd0, passed_cnt}, 32'd21);

        // load coinciding with a token at ph=div-1
        do_load(4'd2, 1'b0);
        cyc("t4_pre", 4'b0001, 4'b0000);
        load    = 1'b1;
        div_in  = 4'd3;
        mode_in = 1'b0;
        cyc("t4_ld", 4'b0001, 4'b0001);
        load = 1'b0;
        cyc("t4_p0", 4'b0001, 4'b0000);
        cyc("t4_p1", 4'b0001, 4'b0000);
        cyc("t4_p2", 4'b0001, 4'b0001);
        // load must override the phase advance of its own cycle
        cyc("t4b_pre", 4'b0001, 4'b0000);
        load    = 1'b1;
        div_in  = 4'd2;
        mode_in = 1'b1;
        cyc("t4b_ld", 4'b0001, 4'b0000);
        load = 1'b0;
        cyc("t4b_p0", 4'b0001, 4'b0001);
        cyc("t4b_p1", 4'b0001, 4'b0000);
        chk("t4_cnt", {16'd0, passed_cnt}, 32'd24);

        // saturation on the 4-bit counter
        do_load(4'd1, 1'b0);
        clr_cnt = 1'b1;
        @(posedge clk);
        #1;
        clr_cnt = 1'b0;
        chk("t5_clr0", {28'd0, passed_cnt4}, 32'd0);
        chk("t5_sat0", {31'd0, cnt_sat4}, 32'd0);
        cyc("t5_b", 4'hF, 4'hF);
        chk("t5_c4", {28'd0, passed_cnt4}, 32'd4);
        cyc("t5_b", 4'hF, 4'hF);
        chk("t5_c8", {28'd0, passed_cnt4}, 32'd8);
        cyc("t5_b", 4'hF, 4'hF);
        chk("t5_c12", {28'd0, passed_cnt4}, 32'd12);
        chk("t5_nsat", {31'd0, cnt_sat4}, 32'd0);
        cyc("t5_b", 4'hF, 4'hF);
        chk("t5_c15", {28'd0, passed_cnt4}, 32'd15);
        chk("t5_sat", {31'd0, cnt_sat4}, 32'd1);
        cyc("t5_b", 4'hF, 4'hF);
        chk("t5_hold", {28'd0, passed_cnt4}, 32'd15);
        chk("t5_wide", {16'd0, passed_cnt}, 32'd20);
        clr_cnt = 1'b1;
        cyc("t5_clrb", 4'hF, 4'hF);
        clr_cnt = 1'b0;
        chk("t5_clr", {28'd0, passed_cnt4}, 32'd0);
        chk("t5_clrs", {31'd0, cnt_sat4}, 32'd0);
        chk("t5_clrw", {16'd0, passed_cnt}, 32'd0);

        // reset mid-stream, then enable gating
        do_load(4'd3, 1'b0);
        cyc("t6_pre", 4'b0001, 4'b0000);
        rst_n = 1'b0;
        cyc("t6_rst", 4'b1111, 4'b0000);
        rst_n = 1'b1;
        chk("t6_cnt", {16'd0, passed_cnt}, 32'd0);
        cyc("t6_d", 4'b0001, 4'b0000);
        cyc("t6_p", 4'b0001, 4'b0001);
        en = 1'b0;
        cyc("t6_en0", 4'b0001, 4'b0000);
        cyc("t6_en0", 4'b0001, 4'b0000);
        en = 1'b1;
        cyc("t6_en1", 4'b0001, 4'b0000);
        cyc("t6_en1", 4'b0001, 4'b0001);
        chk("t6_cnt2", {16'd0, passed_cnt}, 32'd2);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
